// File: rtl/dmd_pkg.sv
// Shared constants and types for the DMD video path.
// Both the frame loader and the video generator import this package.
package dmd_pkg;

    localparam int unsigned DMD_WIDTH  = 128;
    localparam int unsigned DMD_HEIGHT = 32;
    localparam int unsigned DMD_ADDR_W = 13;
    localparam int unsigned DMD_PIX_W  = 4;

    typedef enum logic [1:0] {
        S_WAIT,
        S_HI,
        S_LO
    } state_t;

    // Within a byte, the high nibble is the pixel at the lower address.
    function automatic logic [DMD_PIX_W-1:0] first_pix(input logic [7:0] b);
        return b[7:4];
    endfunction

    function automatic logic [DMD_PIX_W-1:0] second_pix(input logic [7:0] b);
        return b[3:0];
    endfunction

endpackage

// File: rtl/dmd_frame_loader_if.sv
// Byte-stream input and frame-buffer write port of the DMD frame loader.
// The slave modport is the loader side; master is the source/buffer side.
interface dmd_frame_loader_if #(
    parameter int unsigned ADDR_W = dmd_pkg::DMD_ADDR_W
) ();
    import dmd_pkg::*;

    logic [7:0]           in_data;
    logic                 in_sof;
    logic                 in_valid;
    logic                 in_ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DMD_PIX_W-1:0] wr_data;
    logic                 frame_done;
    logic                 sof_err;

    modport slave (
        input  in_data, in_sof, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, frame_done, sof_err
    );

    modport master (
        output in_data, in_sof, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, frame_done, sof_err
    );

endinterface

// File: rtl/dmd_frame_loader.sv
// Unpacks a byte stream of nibble pixels into linear frame-buffer writes,
// framed by a start-of-frame flag; flags completed and restarted frames.
module dmd_frame_loader
    import dmd_pkg::*;
#(
    parameter int unsigned WIDTH  = DMD_WIDTH,
    parameter int unsigned HEIGHT = DMD_HEIGHT,
    parameter int unsigned ADDR_W = DMD_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    dmd_frame_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DMD_PIX_W-1:0] lo_q, lo_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DMD_PIX_W-1:0] wr_data_q, wr_data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 ready;
    logic                 accept;
    logic [ADDR_W-1:0]    addr_p1;

    // Held low during reset so nothing is consumed in the reset cycle.
    assign ready   = !rst && (state_q != S_LO);
    assign accept  = bus.in_valid && ready;
    assign addr_p1 = addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT;
            addr_q    <= '0;
            lo_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_WAIT, S_HI: begin
                // In S_WAIT only a start-of-frame byte opens a frame; others drop.
                if (accept && (bus.in_sof || state_q == S_HI)) begin
                    err_d     = (state_q == S_HI) && bus.in_sof;
                    addr_d    = bus.in_sof ? '0 : addr_q;
                    wr_en_d   = 1'b1;
                    wr_addr_d = bus.in_sof ? '0 : addr_q;
                    wr_data_d = first_pix(bus.in_data);
                    lo_d      = second_pix(bus.in_data);
                    state_d   = S_LO;
                end
            end
            S_LO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_p1;
                wr_data_d = lo_q;
                if (addr_p1 == LAST_ADDR) begin
                    done_d  = 1'b1;
                    addr_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    addr_d  = addr_q + ADDR_W'(2);
                    state_d = S_HI;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign bus.in_ready   = ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = done_q;
    assign bus.sof_err    = err_q;

endmodule

// File: doc/dmd_frame_loader.md
# dmd_frame_loader

Upstream stage of the LCD DMD video path. Accepts a byte stream of packed 4-bit pixel brightness values (two pixels per byte, high nibble first), frames it on a start-of-frame flag, and writes the pixels linearly into the write port of the dual-port frame buffer. The buffer's read port is scanned by the video generator. The block emits a one-cycle pulse when a full frame has been written.

## Interface
Parameters:
- `WIDTH`, 128, pixels per row; must be a power of two.
- `HEIGHT`, 32, rows per frame.
- `ADDR_W`, 13, frame buffer address width; requires WIDTH*HEIGHT ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  the one clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  two pixels: [7:4] lower address, [3:0] next address.
- `in_sof`  in  1  qualifies `in_data` as the first byte of a frame.
- `in_valid`  in  1  source has a byte.
- `in_ready`  out  1  loader accepts the byte this cycle.
- `wr_en`  out  1  frame buffer write strobe.
- `wr_addr`  out  ADDR_W  write address, computed as y*WIDTH + x.
- `wr_data`  out  4  pixel brightness.
- `frame_done`  out  1  one-cycle pulse, last pixel of the frame written.
- `sof_err`  out  1  one-cycle pulse, frame restarted before completion.

## Operation
- A byte is accepted on any cycle with `in_valid && in_ready`.
- FSM states:
  - **S_WAIT**
    - `in_ready`=1.
    - Accepted bytes with `in_sof`=0 are discarded.
    - An accepted byte with `in_sof`=1: write its high nibble at address 0, latch the low nibble, go to S_LO.
  - **S_HI**
    - `in_ready`=1.
    - Accepted byte with `in_sof`=0: write its high nibble at the current address, latch the low nibble, go to S_LO.
    - Accepted byte with `in_sof`=1: pulse `sof_err`, reset the address to 0, then treat the byte as a frame start.
    - No byte accepted: stay in S_HI, `wr_en`=0.
  - **S_LO**
    - `in_ready`=0.
    - Write the latched low nibble at current address + 1.
    - If that address is WIDTH*HEIGHT−1: pulse `frame_done`, go to S_WAIT.
    - Otherwise advance the address by 2 and go to S_HI.
- Address is a single linear counter of ADDR_W bits; x = counter[log2(WIDTH)−1:0], y = the upper bits. No wrap beyond WIDTH*HEIGHT−1.
- Bytes arriving after a completed frame without `in_sof` are accepted and dropped in S_WAIT, so the source never stalls.
- Odd pixel counts are unsupported. WIDTH*HEIGHT is even by construction.
- `wr_data` holds the raw 4-bit value. Brightness scaling belongs to the video generator.

## Timing
- Reset state: S_WAIT, address 0.
- Reset values of outputs: `in_ready`=0 during the reset cycle and 1 from the first cycle after reset; `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `sof_err`=0.
- Write outputs are registered.
  - High-nibble write appears on `wr_*` the cycle after acceptance.
  - Low-nibble write appears the cycle after that.
- `frame_done` is asserted in the same cycle as the final `wr_en`.
- `sof_err` is asserted in the cycle after the offending byte is accepted.
- Throughput: at most one byte per 2 cycles. `in_ready` is low in S_LO.
- Reset mid-frame: the partially written buffer is left as is, with no further writes. The loader waits for the next `in_sof`.
- `rst` takes priority over every other condition in the same cycle.

## Structure
- Shared package `dmd_pkg`:
  - constants DMD_WIDTH=128, DMD_HEIGHT=32, DMD_ADDR_W=13, DMD_PIX_W=4;
  - state enum {S_WAIT, S_HI, S_LO}.
- The video generator imports the same constants.
- No sub-module. The frame buffer is replaced by a dual-port BRAM `dp_bram` instantiated at top level: port A reads for the video generator, port B writes from this block.

## Test plan
- Reset, then a full frame of 2048 bytes, byte k = k[7:0], `in_sof` on byte 0, `in_valid` held high:
  - 4096 writes at addr 0..4095;
  - addr 2n gets byte n [7:4] and addr 2n+1 gets byte n [3:0];
  - a single `frame_done` on the write to addr 4095;
  - `in_ready` toggles 1,0,1,0.
- Non-SOF bytes 0xFF ×5 before any SOF: all accepted, `wr_en` never asserts.
- Restart mid-frame:
  - SOF, then 10 bytes, then a second SOF byte 0xA5;
  - `sof_err` pulses once;
  - the next writes are addr 0 = 0xA and addr 1 = 0x5;
  - no `frame_done`.
- Random `in_valid` gaps (30% idle) across a full frame: same buffer contents as the gap-free run, `frame_done` exactly once.
- `rst` asserted at byte 1000:
  - `wr_en`=0 from the next cycle;
  - bytes without SOF after reset cause no writes;
  - a new SOF frame starts at addr 0.
- Bytes after `frame_done` without SOF: accepted, no writes, no pulses.
